// File: rtl/xbar_rr_arbiter.sv
// Per-slave round-robin arbiter for the 4-port crossbar: picks one requesting master,
// holds the grant until the slave acks, and tracks which master owns returning read data.
module xbar_rr_arbiter #(
    parameter int M  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [M-1:0]  m_req,
    input  logic [M-1:0]  m_cmd,
    input  logic          s_ack,
    output logic          s_req,
    output logic [M-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic [M-1:0]  m_ack,
    output logic          rvalid,
    output logic [IW-1:0] rid
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state_r, state_next_s;
    logic [IW-1:0] ptr_r, ptr_next_s;
    logic [IW-1:0] lock_id_r, lock_id_next_s;
    logic          rvalid_r;
    logic [IW-1:0] rid_r;

    logic [IW:0]   pick_s;
    logic          active_s;
    logic          live_s;
    logic [IW-1:0] sel_id_s;
    logic          xfer_s;

    // Returns {found, index} of the first requester at or after base, wrapping mod M.
    function automatic logic [IW:0] rr_pick(input logic [M-1:0] req, input logic [IW-1:0] base);
        logic [IW:0]   pick;
        logic [IW-1:0] idx;
        pick = {(IW+1){1'b0}};
        for (int k = M - 1; k >= 0; k--) begin
            idx = IW'((int'(base) + k) % M);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] id);
        if (int'(id) == M - 1) begin
            return {IW{1'b0}};
        end else begin
            return id + IW'(1);
        end
    endfunction

    function automatic logic [M-1:0] onehot(input logic [IW-1:0] id);
        logic [M-1:0] oh;
        oh     = {M{1'b0}};
        oh[id] = 1'b1;
        return oh;
    endfunction

    assign pick_s = rr_pick(m_req, ptr_r);

    // Next-state, pointer update and grant selection.
    always_comb begin
        state_next_s   = state_r;
        ptr_next_s     = ptr_r;
        lock_id_next_s = lock_id_r;
        active_s       = 1'b0;
        sel_id_s       = {IW{1'b0}};
        case (state_r)
            IDLE: begin
                if (pick_s[IW]) begin
                    active_s = 1'b1;
                    sel_id_s = pick_s[IW-1:0];
                    if (s_ack) begin
                        ptr_next_s = inc_mod(pick_s[IW-1:0]);
                    end else begin
                        lock_id_next_s = pick_s[IW-1:0];
                        state_next_s   = LOCK;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOCK: begin
                // A master dropping its request before ack abandons the lock without a transfer.
                if (m_req[lock_id_r]) begin
                    active_s = 1'b1;
                    sel_id_s = lock_id_r;
                    if (s_ack) begin
                        ptr_next_s   = inc_mod(lock_id_r);
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = LOCK;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign live_s   = active_s & reset;
    assign xfer_s   = live_s & s_ack;
    assign s_req    = live_s;
    assign grant    = live_s ? onehot(sel_id_s) : {M{1'b0}};
    assign grant_id = live_s ? sel_id_s : {IW{1'b0}};
    assign m_ack    = xfer_s ? grant : {M{1'b0}};

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            ptr_r     <= {IW{1'b0}};
            lock_id_r <= {IW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            ptr_r     <= ptr_next_s;
            lock_id_r <= lock_id_next_s;
        end
    end

    // Read-return tracking: data arrives the cycle after the read ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_r <= 1'b0;
            rid_r    <= {IW{1'b0}};
        end else if (xfer_s && !m_cmd[grant_id]) begin
            rvalid_r <= 1'b1;
            rid_r    <= grant_id;
        end else begin
            rvalid_r <= 1'b0;
        end
    end

    assign rvalid = rvalid_r;
    assign rid    = rid_r;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Randomized and directed bench for xbar_rr_arbiter against a transaction-level
// round-robin model (owner/pointer kept as plain integers).
module tb_xbar_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] m_req;
    logic [3:0] m_cmd;
    logic       s_ack;
    logic       s_req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic [3:0] m_ack;
    logic       rvalid;
    logic [1:0] rid;

    int vectors;
    int miscompares;

    int ptr_m;
    int owner_m;
    bit rvalid_m;
    int rid_m;

    xbar_rr_arbiter #(.M(4), .IW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    (m_req),
        .m_cmd    (m_cmd),
        .s_ack    (s_ack),
        .s_req    (s_req),
        .grant    (grant),
        .grant_id (grant_id),
        .m_ack    (m_ack),
        .rvalid   (rvalid),
        .rid      (rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        ptr_m    = 0;
        owner_m  = -1;
        rvalid_m = 1'b0;
        rid_m    = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        m_req = 4'b0000;
        m_cmd = 4'b0000;
        s_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // One clock: ack_mode 0 = no ack, 1 = ack, 2 = ack exactly when a request is granted.
    task automatic cycle(input logic [3:0] req, input logic [3:0] cmd, input int ack_mode,
                         output logic [3:0] og, output logic ov, output logic [1:0] orid);
        int         g;
        int         idx;
        logic       ack;
        logic [3:0] eg;
        logic [3:0] em;
        g = -1;
        if (owner_m >= 0) begin
            idx = owner_m;
            if (req[idx[1:0]]) g = owner_m;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = (ptr_m + k) % 4;
                if (g < 0 && req[idx[1:0]]) g = idx;
            end
        end
        ack = (ack_mode == 2) ? (g >= 0) : (ack_mode == 1);
        eg  = (g >= 0) ? 4'(1 << g) : 4'b0000;
        em  = ack ? eg : 4'b0000;
        m_req = req;
        m_cmd = cmd;
        s_ack = ack;
        #1;
        vectors++;
        if (grant !== eg) begin
            miscompares++;
            $display("FAIL grant t=%0t got %b expected %b", $time, grant, eg);
        end
        vectors++;
        if (grant_id !== 2'((g >= 0) ? g : 0)) begin
            miscompares++;
            $display("FAIL grant_id t=%0t got %0d expected %0d", $time, grant_id, (g >= 0) ? g : 0);
        end
        vectors++;
        if (s_req !== (g >= 0)) begin
            miscompares++;
            $display("FAIL s_req t=%0t got %b expected %b", $time, s_req, (g >= 0));
        end
        vectors++;
        if (m_ack !== em) begin
            miscompares++;
            $display("FAIL m_ack t=%0t got %b expected %b", $time, m_ack, em);
        end
        vectors++;
        if (rvalid !== rvalid_m) begin
            miscompares++;
            $display("FAIL rvalid t=%0t got %b expected %b", $time, rvalid, rvalid_m);
        end
        vectors++;
        if (rid !== 2'(rid_m)) begin
            miscompares++;
            $display("FAIL rid t=%0t got %0d expected %0d", $time, rid, rid_m);
        end
        og   = grant;
        ov   = rvalid;
        orid = rid;
        @(posedge clk);
        if (g >= 0 && ack) begin
            idx      = g;
            ptr_m    = (g + 1) % 4;
            owner_m  = -1;
            rvalid_m = !cmd[idx[1:0]];
            rid_m    = rvalid_m ? g : rid_m;
        end else begin
            rvalid_m = 1'b0;
            owner_m  = g;
        end
        @(negedge clk);
    endtask

    task automatic reset_check(input string name);
        reset = 1'b0;
        #1;
        vectors++;
        if ({grant, s_req, m_ack} !== 9'b0) begin
            miscompares++;
            $display("FAIL %s_comb got grant=%b s_req=%b m_ack=%b expected all zero", name, grant, s_req, m_ack);
        end
        vectors++;
        if ({rvalid, rid} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s_rd got rvalid=%b rid=%0d expected 0/0", name, rvalid, rid);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_req = 4'b1111;
        m_cmd = 4'b0000;
        s_ack = 1'b1;
        @(negedge clk);
        reset_check("reset");
    endtask

    task automatic test_single();
        logic [3:0] og; logic ov; logic [1:0] orid;
        apply_reset();
        cycle(4'b0001, 4'b0000, 2, og, ov, orid);
        vectors++;
        if (og !== 4'b0001) begin miscompares++; $display("FAIL t1_grant got %b expected 0001", og); end
        cycle(4'b0011, 4'b1111, 2, og, ov, orid);
        vectors++;
        if (og !== 4'b0010) begin miscompares++; $display("FAIL t1_ptr got %b expected 0010", og); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] og; logic ov; logic [1:0] orid;
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 4'b0000, 2, og, ov, orid);
            vectors++;
            if (og !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL t2_rr step %0d got %b expected %b", i, og, exp_seq[i]);
            end
            if (i > 0) begin
                vectors++;
                if (!ov || orid !== 2'(i - 1)) begin
                    miscompares++;
                    $display("FAIL t2_rd step %0d got rvalid=%b rid=%0d expected 1/%0d", i, ov, orid, i - 1);
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [3:0] og; logic ov; logic [1:0] orid;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0011, 4'b1111, (i == 3) ? 1 : 0, og, ov, orid);
            vectors++;
            if (og !== 4'b0001) begin miscompares++; $display("FAIL t3_hold cyc %0d got %b expected 0001", i, og); end
        end
        cycle(4'b0011, 4'b1111, 2, og, ov, orid);
        vectors++;
        if (og !== 4'b0010) begin miscompares++; $display("FAIL t3_next got %b expected 0010", og); end
        cycle(4'b1100, 4'b1111, 0, og, ov, orid);
        cycle(4'b1011, 4'b1111, 1, og, ov, orid);
        vectors++;
        if (og !== 4'b0000) begin miscompares++; $display("FAIL t3_drop got %b expected 0000", og); end
    endtask

    task automatic test_read();
        logic [3:0] og; logic ov; logic [1:0] orid;
        apply_reset();
        cycle(4'b0100, 4'b1011, 1, og, ov, orid);
        cycle(4'b0000, 4'b0000, 1, og, ov, orid);
        vectors++;
        if (!ov || orid !== 2'd2) begin miscompares++; $display("FAIL t4_read got rvalid=%b rid=%0d expected 1/2", ov, orid); end
        cycle(4'b0100, 4'b0100, 1, og, ov, orid);
        vectors++;
        if (ov !== 1'b0) begin miscompares++; $display("FAIL t4_pulse got rvalid=%b expected 0", ov); end
        cycle(4'b0000, 4'b0000, 0, og, ov, orid);
        vectors++;
        if (ov !== 1'b0) begin miscompares++; $display("FAIL t4_write got rvalid=%b expected 0", ov); end
    endtask

    task automatic test_wrap();
        logic [3:0] og; logic ov; logic [1:0] orid;
        apply_reset();
        cycle(4'b0100, 4'b0000, 2, og, ov, orid);
        cycle(4'b1001, 4'b0000, 2, og, ov, orid);
        vectors++;
        if (og !== 4'b1000) begin miscompares++; $display("FAIL t5_first got %b expected 1000", og); end
        cycle(4'b1001, 4'b0000, 2, og, ov, orid);
        vectors++;
        if (og !== 4'b0001) begin miscompares++; $display("FAIL t5_wrap got %b expected 0001", og); end
    endtask

    task automatic test_reset_lock();
        logic [3:0] og; logic ov; logic [1:0] orid;
        apply_reset();
        cycle(4'b0010, 4'b0000, 1, og, ov, orid);
        m_req = 4'b0000;
        reset_check("t6_midread");
        cycle(4'b0100, 4'b0000, 0, og, ov, orid);
        m_req = 4'b0100;
        reset_check("t6_midlock");
        cycle(4'b0110, 4'b0000, 2, og, ov, orid);
        vectors++;
        if (og !== 4'b0010) begin miscompares++; $display("FAIL t6_after got %b expected 0010", og); end
    endtask

    task automatic test_random();
        logic [3:0] og; logic ov; logic [1:0] orid;
        logic [3:0] req;
        int         idx;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            req = 4'($urandom_range(0, 15));
            if (owner_m >= 0 && $urandom_range(0, 9) != 0) begin
                idx = owner_m;
                req[idx[1:0]] = 1'b1;
            end
            cycle(req, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), og, ov, orid);
            if ($urandom_range(0, 59) == 0) begin
                reset_check("rand_reset");
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_read();
        test_wrap();
        test_reset_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
